// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a common-cathode seven-segment display with
//   DIGITS positions. A packed digit word is double-buffered so the shown
//   content only changes on frame boundaries. Each position gets a slot of
//   SCAN_DIV cycles, the first GUARD cycles of which keep every digit dark to
//   avoid ghosting. Nibbles are decoded to active-high segments, with optional
//   hex glyphs and leading-zero blanking.
//
// Ports
//   sys_clk      system clock, rising edge
//   sys_rst_n    asynchronous active-low reset
//   digits_in    packed nibbles, digit k = digits_in[4k+3:4k], digit 0 rightmost
//   dp_in        decimal-point request per position
//   load         capture digits_in/dp_in into the staging buffer
//   blank_in     force segments and dp off while scanning continues
//   seg          segments {g,f,e,d,c,b,a}, active-high
//   seg_dp       decimal point, active-high
//   dig_n        digit enables, active-low, at most one low
//   frame_start  one-cycle pulse when the slot of digit 0 begins
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 1,
  parameter int HEX_EN   = 0,
  parameter int LZ_BLANK = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_in,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame_start
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Nibble to {g,f,e,d,c,b,a}; 10..15 are blank unless hex glyphs are enabled.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = (HEX_EN != 0) ? 7'h77 : 7'h00;
      4'd11:   s = (HEX_EN != 0) ? 7'h7C : 7'h00;
      4'd12:   s = (HEX_EN != 0) ? 7'h39 : 7'h00;
      4'd13:   s = (HEX_EN != 0) ? 7'h5E : 7'h00;
      4'd14:   s = (HEX_EN != 0) ? 7'h79 : 7'h00;
      default: s = (HEX_EN != 0) ? 7'h71 : 7'h00;
    endcase
    return s;
  endfunction

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] stg_dig_q, stg_dig_d;
  logic [DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] disp_dig_q, disp_dig_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dign_q, dign_d;
  logic                fs_q, fs_d;

  logic                tick, boundary, in_guard;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_lz;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;

  // ---- stage 0: scan position and double buffer ----
  assign tick     = (pre_q == PRE_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  always_comb begin
    pre_d      = tick ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    stg_dig_d  = load ? digits_in : stg_dig_q;
    stg_dp_d   = load ? dp_in     : stg_dp_q;
    pend_d     = pend_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    if (boundary) begin
      // A load landing on the boundary cycle bypasses staging so it is not
      // delayed by a whole extra frame.
      pend_d = 1'b0;
      if (load) begin
        disp_dig_d = digits_in;
        disp_dp_d  = dp_in;
      end else if (pend_q) begin
        disp_dig_d = stg_dig_q;
        disp_dp_d  = stg_dp_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  // Leading-zero mask: a position is blank when it and every position above
  // it hold zero; position 0 always shows.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (disp_dig_q[4*k +: 4] == 4'd0);
      lz_mask[k] = (LZ_BLANK != 0) && (k != 0) && zero_above;
    end
  end

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = disp_dig_q[4*k +: 4];
        cur_dp  = disp_dp_q[k];
        cur_lz  = lz_mask[k];
      end
    end
  end

  // ---- stage 1: registered pin outputs ----
  assign in_guard = (pre_q < PRE_W'(GUARD));

  always_comb begin
    seg_d  = (blank_in || in_guard || cur_lz) ? 7'h00 : decode(cur_nib);
    dp_d   = !(blank_in || in_guard) && cur_dp;
    dign_d = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!in_guard && (idx_q == IDX_W'(k))) dign_d[k] = 1'b0;
    end
    fs_d   = (pre_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q      <= '0;
      idx_q      <= '0;
      stg_dig_q  <= '0;
      stg_dp_q   <= '0;
      pend_q     <= 1'b0;
      disp_dig_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      dign_q     <= '1;
      fs_q       <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      stg_dig_q  <= stg_dig_d;
      stg_dp_q   <= stg_dp_d;
      pend_q     <= pend_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dign_q     <= dign_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign seg_dp      = dp_q;
  assign dig_n       = dign_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_in = 1'b0;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  dign0, dign1;
  logic        fs0, fs1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD),
                     .HEX_EN(0), .LZ_BLANK(1)) u_dec (
    .sys_clk(clk), .sys_rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .blank_in(blank_in), .seg(seg0), .seg_dp(dp0),
    .dig_n(dign0), .frame_start(fs0));

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD),
                     .HEX_EN(1), .LZ_BLANK(1)) u_hex (
    .sys_clk(clk), .sys_rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .blank_in(blank_in), .seg(seg1), .seg_dp(dp1),
    .dig_n(dign1), .frame_start(fs1));

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset release determines slot and frame;
  // a load made in frame f becomes the display content from frame f+1 on.
  int          t = 0;
  int          last_t = -1;
  logic [15:0] m_disp = 16'h0, m_new = 16'h0;
  logic [3:0]  m_ddp = 4'h0, m_newdp = 4'h0;
  bit          m_have = 1'b0;
  int          m_newf = 0;
  logic [6:0]  e_seg0 = 7'h0, e_seg1 = 7'h0;
  logic        e_dp0 = 1'b0, e_dp1 = 1'b0;
  logic [3:0]  e_dign = 4'hF;
  logic        e_fs = 1'b0;

  logic [3:0]  seq [6];
  logic [6:0]  lit_hex [16];
  logic [6:0]  lit_dec [16];

  function automatic logic [6:0] glyph(input int v, input bit hex);
    string s;
    logic [6:0] r;
    r = 7'h0;
    case (v)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      9: s = "abcdfg";
      10: s = hex ? "abcefg" : "";
      11: s = hex ? "cdefg" : "";
      12: s = hex ? "adef" : "";
      13: s = hex ? "bcdeg" : "";
      14: s = hex ? "adefg" : "";
      15: s = hex ? "aefg" : "";
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) r = r | 7'(1 << (int'(s[i]) - 97));
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    int pre, idx, f, nib;
    bit dark, lz, dpb;
    if (!rst_n) begin
      t = 0; last_t = -1; m_disp = 16'h0; m_ddp = 4'h0; m_have = 1'b0;
      e_seg0 = 7'h0; e_seg1 = 7'h0; e_dp0 = 1'b0; e_dp1 = 1'b0;
      e_dign = 4'hF; e_fs = 1'b0;
    end else begin
      pre = t % SCAN_DIV;
      idx = (t / SCAN_DIV) % DIGITS;
      f   = t / FRAME;
      if (m_have && m_newf < f) begin
        m_disp = m_new; m_ddp = m_newdp; m_have = 1'b0;
      end
      dark   = blank_in || (pre < GUARD);
      nib    = int'((m_disp >> (4 * idx)) & 16'hF);
      lz     = (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
      dpb    = ((m_ddp >> idx) & 4'h1) != 4'h0;
      e_seg0 = (dark || lz) ? 7'h0 : glyph(nib, 1'b0);
      e_seg1 = (dark || lz) ? 7'h0 : glyph(nib, 1'b1);
      e_dp0  = !dark && dpb;
      e_dp1  = e_dp0;
      e_dign = (pre < GUARD) ? 4'hF : (4'hF & ~4'(1 << idx));
      e_fs   = (pre == 0) && (idx == 0);
      if (load) begin
        m_new = digits_in; m_newdp = dp_in; m_newf = f; m_have = 1'b1;
      end
      last_t = t;
      t++;
    end
  endtask

  task automatic compare();
    check("seg_dec", seg0, e_seg0);
    check("seg_hex", seg1, e_seg1);
    check("dp_dec", dp0, e_dp0);
    check("dp_hex", dp1, e_dp1);
    check("dign_dec", dign0, e_dign);
    check("dign_hex", dign1, e_dign);
    check("fs_dec", fs0, e_fs);
    check("fs_hex", fs1, e_fs);
  endtask

  task automatic step();
    @(posedge clk);
    model_eval();
    @(negedge clk);
    compare();
  endtask

  // Step until the last output reflects slot phase ph of frame >= minf.
  task automatic goto(input int ph, input int minf);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(last_t >= 0 && last_t % FRAME == ph && last_t / FRAME >= minf) && n < 400);
    if (!(last_t >= 0 && last_t % FRAME == ph && last_t / FRAME >= minf)) begin
      checks++; errors++;
      $display("FAIL goto: phase %0d frame %0d not reached", ph, minf);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, output int lf);
    digits_in = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
    lf = last_t / FRAME;
  endtask

  initial begin
    int lf, n;
    seq = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
    lit_hex = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    for (int i = 0; i < 16; i++) lit_dec[i] = (i < 10) ? lit_hex[i] : 7'h00;

    // Reset and idle scan
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_dign", dign0, 4'hF);
      check("rst_seg", seg0, 7'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("dign_seq", dign0, seq[i]);
      if (i == 0) check("fs_first", fs0, 1'b1);
    end
    n = 6;
    do begin
      step();
      n++;
    end while (!fs0 && n < 40);
    check("fs_period", n - 1, 16);

    // Decode sweep on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), 4'h0, lf);
      goto(1, lf + 1);
      check("sweep_dec", seg0, lit_dec[v]);
      check("sweep_hex", seg1, lit_hex[v]);
    end

    // Double buffer: mid-frame load, then a load on the boundary cycle
    goto(5, 0);
    do_load(16'h1234, 4'h0, lf);
    goto(1, lf + 1);
    check("dbuf_d0", seg0, 7'h66);
    goto(5, lf + 1);
    check("dbuf_d1", seg0, 7'h4F);
    goto(13, lf + 1);
    check("dbuf_d3", seg0, 7'h06);
    goto(14, 0);
    do_load(16'h0008, 4'h0, lf);
    check("bnd_phase", last_t % FRAME, 15);
    goto(1, lf + 1);
    check("bnd_d0", seg0, 7'h7F);

    // Leading zeros and decimal point
    do_load(16'h0050, 4'b1000, lf);
    goto(1, lf + 1);
    check("lz_d0", seg0, 7'h3F);
    goto(5, lf + 1);
    check("lz_d1", seg0, 7'h6D);
    goto(9, lf + 1);
    check("lz_d2", seg0, 7'h00);
    goto(13, lf + 1);
    check("lz_d3", seg0, 7'h00);
    check("lz_dp3", dp0, 1'b1);
    do_load(16'h0000, 4'h0, lf);
    goto(1, lf + 1);
    check("zero_d0", seg0, 7'h3F);
    goto(5, lf + 1);
    check("zero_d1", seg0, 7'h00);

    // blank_in for a full frame
    do_load(16'h8888, 4'hF, lf);
    goto(15, lf + 1);
    blank_in = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      check("blank_seg", seg0, 7'h00);
      check("blank_dp", dp0, 1'b0);
      if (i % SCAN_DIV != 0) check("blank_scan", dign0, 4'hF & ~4'(1 << (i / SCAN_DIV)));
    end
    blank_in = 1'b0;

    // Asynchronous reset mid-slot drops pending data
    goto(6, 0);
    do_load(16'h0777, 4'h0, lf);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_dign", dign0, 4'hF);
    check("arst_seg", seg0, 7'h00);
    check("arst_fs", fs0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("arst_d0", seg0, 7'h3F);
    goto(1, 1);
    check("arst_lost", seg0, 7'h3F);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      v = 16'h0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(1, 0) == 1) v = v | (16'($urandom_range(15, 1)) << (4 * k));
      digits_in = v;
      dp_in     = 4'($urandom_range(15, 0));
      load      = ($urandom_range(7, 0) == 0);
      if ($urandom_range(31, 0) == 0) blank_in = ~blank_in;
      step();
    end
    load = 1'b0;
    blank_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
